// File: rtl/sensor_pkg.sv
`default_nettype none
//============================================================================
// Module   : sensor_pkg
// Purpose  : Shared types and default sizing for the sensor reader slice.
// Config   : SENSOR_READER_FALL_EN (used by sensor_reader) -- report falling edges
// Revision : 1.0  initial release
//============================================================================
package sensor_pkg;

   // Debounce FSM states
   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      ST_RISE = 2'd1,
      ST_HI   = 2'd2,
      ST_FALL = 2'd3
   } deb_state_t;

   localparam int DEB_CYCLES_DEF = 4;
   localparam int TS_W_DEF       = 16;
   localparam int CNT_W_DEF      = 16;

   // Width of a counter that must hold 0 .. n-1 (never narrower than 1 bit)
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
//============================================================================
// Module   : sensor_debounce
// Purpose  : Debounces the sensor Z line. A new level is accepted after
//            DEB_CYCLES consecutive identical samples; rise/fall strobe
//            high for exactly the cycle whose sample qualifies the edge.
// Revision : 1.0  initial release
//============================================================================
module sensor_debounce
   import sensor_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sens,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int            DW    = cnt_width(DEB_CYCLES);
   localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);

   deb_state_t    state;
   logic [DW-1:0] dcnt;

   // Strobes are combinational so the record slot can load on the same edge
   // that moves LEVEL; with DEB_CYCLES=1 a single opposite sample qualifies.
   assign rise = sens &&
                 (((state == ST_LO) && (DEB_CYCLES == 1)) ||
                  ((state == ST_RISE) && (dcnt == DLAST)));
   assign fall = !sens &&
                 (((state == ST_HI) && (DEB_CYCLES == 1)) ||
                  ((state == ST_FALL) && (dcnt == DLAST)));

   // Debounce FSM; LEVEL holds the last accepted level, so the pending
   // states ST_RISE/ST_FALL keep reporting the old one until qualification.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_HI;
         dcnt  <= '0;
         level <= 1'b1;
      end else begin
         if (rise)
            level <= 1'b1;
         else if (fall)
            level <= 1'b0;

         case (state)
            ST_LO: begin
               if (sens) begin
                  if (DEB_CYCLES == 1) begin
                     state <= ST_HI;
                     dcnt  <= '0;
                  end else begin
                     state <= ST_RISE;
                     dcnt  <= DW'(1);
                  end
               end
            end
            ST_RISE: begin
               if (!sens) begin
                  state <= ST_LO;
                  dcnt  <= '0;
               end else if (dcnt == DLAST) begin
                  state <= ST_HI;
                  dcnt  <= '0;
               end else begin
                  dcnt  <= dcnt + 1'b1;
               end
            end
            ST_HI: begin
               if (!sens) begin
                  if (DEB_CYCLES == 1) begin
                     state <= ST_LO;
                     dcnt  <= '0;
                  end else begin
                     state <= ST_FALL;
                     dcnt  <= DW'(1);
                  end
               end
            end
            ST_FALL: begin
               if (sens) begin
                  state <= ST_HI;
                  dcnt  <= '0;
               end else if (dcnt == DLAST) begin
                  state <= ST_LO;
                  dcnt  <= '0;
               end else begin
                  dcnt  <= dcnt + 1'b1;
               end
            end
            default: begin
               state <= ST_HI;
               dcnt  <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/sensor_reader.sv
`default_nettype none
//============================================================================
// Module   : sensor_reader
// Purpose  : Consumer end of the sensor line: debounce, timestamp qualified
//            edges, present them as a single valid/ready record, count
//            events and flag drops with a sticky overflow.
// Config   : SENSOR_READER_FALL_EN defined  -> falling edges reported too
//            undefined (default)            -> rising edges only, EV_RISE=1
// Revision : 1.0  initial release
//============================================================================
module sensor_reader
   import sensor_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int TS_W       = TS_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             CLK,
   input  logic             MR,
   input  logic             SENS,
   output logic             LEVEL,
   output logic             EV_VALID,
   input  logic             EV_READY,
   output logic [TS_W-1:0]  EV_TS,
   output logic             EV_RISE,
   output logic [CNT_W-1:0] EV_CNT,
   output logic             OVF
);

   logic            rise;
   logic            fall;
   logic            ev;
   logic            load;
   logic [TS_W-1:0] ts;

   sensor_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk   (CLK),
      .rst   (MR),
      .sens  (SENS),
      .level (LEVEL),
      .rise  (rise),
      .fall  (fall)
   );

`ifdef SENSOR_READER_FALL_EN
   assign ev = rise | fall;

   // Edge direction travels with the record; frozen while the slot is held
   always_ff @(posedge CLK) begin
      if (MR)
         EV_RISE <= 1'b0;
      else if (load)
         EV_RISE <= rise;
   end
`else
   logic unused_fall;

   assign ev          = rise;
   assign unused_fall = fall;
   assign EV_RISE     = 1'b1;
`endif

   // Slot is free when empty or being drained by the consumer this very cycle
   assign load = ev && (!EV_VALID || EV_READY);

   // Timestamp counter, record slot, event counter and sticky overflow
   always_ff @(posedge CLK) begin
      if (MR) begin
         ts       <= '0;
         EV_VALID <= 1'b0;
         EV_TS    <= '0;
         EV_CNT   <= '0;
         OVF      <= 1'b0;
      end else begin
         ts <= ts + 1'b1;
         if (ev)
            EV_CNT <= EV_CNT + 1'b1;
         if (load) begin
            EV_VALID <= 1'b1;
            EV_TS    <= ts;
         end else if (ev) begin
            OVF      <= 1'b1;
         end else if (EV_VALID && EV_READY) begin
            EV_VALID <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
